ram_arbiter: RTL
================

// Module: ram_arbiter
// PURPOSE
//  Two-port arbiter placed between unified RAM (dev_ram) and its requesters:
//  port 0 = control unit (fetch + data bus), port 1 = loader/debug master.
//  Registered round-robin grant, one RAM transaction in flight, 2-cycle issue/response cadence.
//  Lets a host load or inspect RAM while the CU runs, without modifying the CU's sequencing.
// PARAMETERS
//  ADDRW  16  RAM byte-address width (matches pkg_ram::RAM_ADDRW)
//  DATAW  64  RAM data width
// PORTS
//  clk           in   1      single clock, all state updates on posedge
//  rst_n         in   1      asynchronous, active-low reset
//  rqN_req       in   1      (N=0,1) request; held high until rqN_gnt
//  rqN_we        in   1      1 = write, 0 = fetch (read)
//  rqN_size      in   2      0 byte, 1 word, 2 long, 3 quad
//  rqN_addr      in   ADDRW  byte address
//  rqN_wdata     in   DATAW  write data (LSB-aligned)
//  rqN_lock      in   1      keep ownership for the next request (RAM_ARB_LOCK_EN only)
//  rqN_gnt       out  1      1-cycle pulse: command issued to RAM this cycle
//  rqN_rvalid    out  1      1-cycle pulse one cycle after gnt; ack for writes, data for reads
//  rqN_rdata     out  DATAW  read data, valid when rqN_rvalid; 0 otherwise
//  ram_op        out  2      pkg_ram op: RAM_NOP / RAM_FETCH / RAM_STORE
//  ram_size      out  2      size of the issued command
//  ram_addr      out  ADDRW  address of the issued command
//  ram_data_in   out  DATAW  write data of the issued command
//  ram_data_out  in   DATAW  RAM read data, valid 1 cycle after FETCH issue
//  busy          out  1      state != ARB_IDLE
// BEHAVIOUR
//  Reset (async assert, sync deassert): state=ARB_IDLE, last=1, owner=0, lock_q=0;
//   all gnt/rvalid=0, rdata=0, ram_op=RAM_NOP, ram_size/addr/data_in=0, busy=0.
//  States: ARB_IDLE -> ARB_ISSUE -> ARB_RESP -> (ARB_ISSUE | ARB_IDLE).
//  ARB_IDLE/ARB_RESP: sample req; winner=port with req, on tie the port != last.
//   Winner's we/size/addr/wdata captured into command registers; next=ARB_ISSUE.
//   No req: next=ARB_IDLE.
//  ARB_ISSUE: ram_* driven from command regs, ram_op=RAM_STORE if we else RAM_FETCH;
//   rq[owner]_gnt=1; last<=owner; next=ARB_RESP. ram_op=RAM_NOP in all other states.
//  ARB_RESP: rq[owner]_rvalid=1, rq[owner]_rdata=ram_data_out (reads and writes);
//   non-owner rdata=0. Arbitration for the next transaction happens in this same cycle.
//  Latency: req sampled cycle N -> gnt N+1 -> rvalid N+2. Back-to-back: 1 txn / 2 cycles.
//  Requester holds req/we/size/addr/wdata stable until gnt. Dropping req before the sampling
//   cycle is legal: no transaction. Dropping req after sampling: transaction still completes.
//  Both requesters continuously requesting: grants alternate 0,1,0,1; max wait = 1 transaction.
//  After reset, the first tie goes to port 0 (last=1).
//  No address/size checking; sizes and alignment pass through to RAM unchanged.
//  Arithmetic: none besides priority compare; no counters wrap.
//  rst_n asserted mid-transaction: txn dropped, no rvalid, outputs reset immediately.
// CONFIGURATION
//  RAM_ARB_LOCK_EN defined: rqN_lock sampled with gnt into lock_q.
//   While lock_q=1, only the owner may win; other port waits even if owner has no req.
//   lock_q clears when owner is granted with lock=0.
//  RAM_ARB_LOCK_EN undefined: rqN_lock ignored (ports remain, unused); pure round-robin.
// TESTING
//  1 reset: rst_n=0 mid-ISSUE -> ram_op=RAM_NOP, all gnt/rvalid=0 same cycle; busy=0.
//  2 single read: rq0 fetch addr=0x0010 size=2, RAM returns 0xDEADBEEF
//    -> gnt0 at N+1 with ram_addr=0x0010, rvalid0 at N+2 with rdata0=0xDEADBEEF.
//  3 write: rq1 we=1 addr=0x0100 size=0 wdata=0xA5
//    -> ram_op=RAM_STORE, ram_data_in=0xA5 at gnt1; rvalid1 next cycle.
//  4 contention: both req held for 8 txns -> gnt order 0,1,0,1,...; one gnt every 2 cycles.
//  5 abort: rq1_req pulsed high then low before sampling -> no gnt1, ram_op stays RAM_NOP.
//  6 lock (RAM_ARB_LOCK_EN): rq1 three txns with lock=1,1,0 while rq0 requests
//    -> gnt1 x3 consecutively, then gnt0; without macro -> alternates 1,0,1,0.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of the unified RAM: one transaction in flight,
// issue/response every two cycles. Optional owner lock via `define RAM_ARB_LOCK_EN.
module ram_arbiter #(
    parameter int ADDRW = 16,
    parameter int DATAW = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rq0_req,
    input  logic             rq0_we,
    input  logic [1:0]       rq0_size,
    input  logic [ADDRW-1:0] rq0_addr,
    input  logic [DATAW-1:0] rq0_wdata,
    input  logic             rq0_lock,
    output logic             rq0_gnt,
    output logic             rq0_rvalid,
    output logic [DATAW-1:0] rq0_rdata,
    input  logic             rq1_req,
    input  logic             rq1_we,
    input  logic [1:0]       rq1_size,
    input  logic [ADDRW-1:0] rq1_addr,
    input  logic [DATAW-1:0] rq1_wdata,
    input  logic             rq1_lock,
    output logic             rq1_gnt,
    output logic             rq1_rvalid,
    output logic [DATAW-1:0] rq1_rdata,
    output logic [1:0]       ram_op,
    output logic [1:0]       ram_size,
    output logic [ADDRW-1:0] ram_addr,
    output logic [DATAW-1:0] ram_data_in,
    input  logic [DATAW-1:0] ram_data_out,
    output logic             busy
);
    localparam logic [1:0] RAM_NOP   = 2'd0;
    localparam logic [1:0] RAM_FETCH = 2'd1;
    localparam logic [1:0] RAM_STORE = 2'd2;

    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_RESP} arb_state_t;

    arb_state_t       state, state_nxt;
    logic             last, owner;
    logic             cmd_we;
    logic [1:0]       cmd_size;
    logic [ADDRW-1:0] cmd_addr;
    logic [DATAW-1:0] cmd_wdata;
    logic             req0_ok, req1_ok, any_req, win, sample;

`ifdef RAM_ARB_LOCK_EN
    logic lock_q;
    // A held lock masks the non-owner, even when the owner is not requesting.
    assign req0_ok = rq0_req && !(lock_q && owner);
    assign req1_ok = rq1_req && !(lock_q && !owner);
`else
    logic unused_lock;
    assign unused_lock = rq0_lock ^ rq1_lock;
    assign req0_ok = rq0_req;
    assign req1_ok = rq1_req;
`endif

    assign any_req = req0_ok || req1_ok;
    assign win     = (req0_ok && req1_ok) ? ~last : req1_ok;
    assign sample  = (state == ARB_IDLE || state == ARB_RESP) && any_req;
    assign busy    = (state != ARB_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            last      <= 1'b1;
            owner     <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_size  <= '0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
`ifdef RAM_ARB_LOCK_EN
            lock_q    <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (sample) begin
                owner     <= win;
                cmd_we    <= win ? rq1_we    : rq0_we;
                cmd_size  <= win ? rq1_size  : rq0_size;
                cmd_addr  <= win ? rq1_addr  : rq0_addr;
                cmd_wdata <= win ? rq1_wdata : rq0_wdata;
            end
            if (state == ARB_ISSUE) begin
                last <= owner;
`ifdef RAM_ARB_LOCK_EN
                lock_q <= owner ? rq1_lock : rq0_lock;
`endif
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        ram_op      = RAM_NOP;
        ram_size    = '0;
        ram_addr    = '0;
        ram_data_in = '0;
        rq0_gnt     = 1'b0;
        rq1_gnt     = 1'b0;
        rq0_rvalid  = 1'b0;
        rq1_rvalid  = 1'b0;
        rq0_rdata   = '0;
        rq1_rdata   = '0;
        case (state)
            ARB_IDLE: state_nxt = any_req ? ARB_ISSUE : ARB_IDLE;
            ARB_ISSUE: begin
                state_nxt   = ARB_RESP;
                ram_op      = cmd_we ? RAM_STORE : RAM_FETCH;
                ram_size    = cmd_size;
                ram_addr    = cmd_addr;
                ram_data_in = cmd_wdata;
                rq0_gnt     = !owner;
                rq1_gnt     = owner;
            end
            ARB_RESP: begin
                // Response for the current owner overlaps arbitration of the next one.
                state_nxt  = any_req ? ARB_ISSUE : ARB_IDLE;
                rq0_rvalid = !owner;
                rq1_rvalid = owner;
                if (owner) rq1_rdata = ram_data_out;
                else       rq0_rdata = ram_data_out;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end
endmodule
